// File: rtl/clk_div_gen.sv
// ---------------------------------------------------------------------------
// clk_div_gen
// Multi-channel clock-enable generator. Every channel runs on clk and produces
// a one-cycle tick every D cycles plus a registered square wave at clk/D.
// The divisor can be reprogrammed at run time; a new value is held pending and
// only takes effect when the channel counter is at, or being forced to, zero,
// so the counter can never run past the terminal count.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   en        per-channel run enable
//   sync_clr  synchronous phase clear, all channels
//   div_in    requested divisors, channel i at [i*CNT_W +: CNT_W]
//   div_ld    per-channel load strobe for div_in
//   tick      registered one-cycle enable pulse
//   sq        registered square wave
//   pend      a captured divisor is waiting to take effect
// ---------------------------------------------------------------------------
module clk_div_gen #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 27,
  parameter int DEF_DIV = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic                    sync_clr,
  input  logic [NUM_CH*CNT_W-1:0] div_in,
  input  logic [NUM_CH-1:0]       div_ld,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       sq,
  output logic [NUM_CH-1:0]       pend
);

  localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO      = '0;
  localparam logic [CNT_W-1:0] DEF_DIV_W = DEF_DIV[CNT_W-1:0];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;

    logic [CNT_W-1:0] din;
    logic [CNT_W-1:0] d_cur;
    logic [CNT_W-1:0] d_nxt;
    logic             force_zero;
    logic             wrap;
    logic             apply;

    assign din        = div_in[gi*CNT_W +: CNT_W];
    // A programmed divisor of 0 behaves like 1.
    assign d_cur      = (div_act_q == ZERO) ? ONE : div_act_q;
    assign force_zero = sync_clr | ~en[gi];
    assign wrap       = (cnt_q == d_cur - ONE);
    // Any edge that leaves cnt at 0 is a safe point to switch divisors.
    assign apply      = force_zero | wrap;

    always_comb begin
      cnt_d      = cnt_q;
      div_act_d  = div_act_q;
      pend_div_d = pend_div_q;
      pend_d     = pend_q;
      tick_d     = 1'b0;
      sq_d       = 1'b0;
      d_nxt      = ONE;

      if (apply) begin
        // A load on an application edge wins over an older pending value.
        if (div_ld[gi]) begin
          div_act_d = din;
          pend_d    = 1'b0;
        end else if (pend_q) begin
          div_act_d = pend_div_q;
          pend_d    = 1'b0;
        end
      end else if (div_ld[gi]) begin
        pend_div_d = din;
        pend_d     = 1'b1;
      end

      if (force_zero) begin
        cnt_d = ZERO;
      end else if (wrap) begin
        cnt_d  = ZERO;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end

      // Square wave follows the divisor that governs the coming cycle.
      d_nxt = (div_act_d == ZERO) ? ONE : div_act_d;
      if (!force_zero) begin
        sq_d = (cnt_d < (d_nxt >> 1));
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q      <= ZERO;
        div_act_q  <= DEF_DIV_W;
        pend_div_q <= ZERO;
        pend_q     <= 1'b0;
        tick_q     <= 1'b0;
        sq_q       <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        div_act_q  <= div_act_d;
        pend_div_q <= pend_div_d;
        pend_q     <= pend_d;
        tick_q     <= tick_d;
        sq_q       <= sq_d;
      end
    end

    assign tick[gi] = tick_q;
    assign sq[gi]   = sq_q;
    assign pend[gi] = pend_q;
  end

endmodule

// File: tb/tb_clk_div_gen.sv
module tb_clk_div_gen;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 27;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH-1:0]       en;
  logic                    sync_clr;
  logic [NUM_CH*CNT_W-1:0] div_in;
  logic [NUM_CH-1:0]       div_ld;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       sq;
  logic [NUM_CH-1:0]       pend;

  int n_chk  = 0;
  int n_fail = 0;

  clk_div_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr),
    .div_in(div_in), .div_ld(div_ld),
    .tick(tick), .sq(sq), .pend(pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ld(input int ch, input int val);
    logic [31:0] v;
    v = val;
    div_in[ch*CNT_W +: CNT_W] = v[CNT_W-1:0];
    div_ld[ch] = 1'b1;
  endtask

  // Disable channel, load divisor directly on that edge, then re-enable.
  task automatic set_div(input int ch, input int val);
    en[ch] = 1'b0;
    drive_ld(ch, val);
    step();
    div_ld = '0;
    en[ch] = 1'b1;
  endtask

  initial begin
    rst = 1'b1; en = '0; sync_clr = 1'b0; div_in = '0; div_ld = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_val("rst_tick", 32'(tick), 32'h0);
    chk_val("rst_sq",   32'(sq),   32'h0);
    chk_val("rst_pend", 32'(pend), 32'h0);
    rst = 1'b0;
    step();

    // Default divisor 4 after reset.
    en[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_val($sformatf("def_tick%0d", k), 32'(tick[0]), 32'((k % 4) == 0));
    end
    // Pending load mid-period, then asynchronous reset.
    drive_ld(0, 7);
    step();
    div_ld = '0;
    chk_val("pre_rst_pend", 32'(pend[0]), 32'h1);
    chk_val("pre_rst_sq",   32'(sq[0]),   32'h1);
    #2 rst = 1'b1;
    #1;
    chk_val("async_rst_pend", 32'(pend[0]), 32'h0);
    chk_val("async_rst_sq",   32'(sq[0]),   32'h0);
    chk_val("async_rst_tick", 32'(tick[0]), 32'h0);
    #1 rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_val($sformatf("post_rst_tick%0d", k), 32'(tick[0]), 32'((k % 4) == 0));
    end

    // Divisor 4: sq 1,0,0,1 with tick on the 4th.
    set_div(0, 4);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk_val($sformatf("d4_tick%0d", k), 32'(tick[0]), 32'((k % 4) == 0));
      chk_val($sformatf("d4_sq%0d", k),   32'(sq[0]),   32'(((k % 4) == 0) || ((k % 4) == 1)));
    end

    // Divisor 3: sq high only on the wrap cycle.
    set_div(0, 3);
    for (int k = 1; k <= 9; k++) begin
      step();
      chk_val($sformatf("d3_tick%0d", k), 32'(tick[0]), 32'((k % 3) == 0));
      chk_val($sformatf("d3_sq%0d", k),   32'(sq[0]),   32'((k % 3) == 0));
    end

    // Divisor 0 and 1: tick every cycle, sq stays low.
    set_div(0, 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_val($sformatf("d0_tick%0d", k), 32'(tick[0]), 32'h1);
      chk_val($sformatf("d0_sq%0d", k),   32'(sq[0]),   32'h0);
    end
    set_div(0, 1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_val($sformatf("d1_tick%0d", k), 32'(tick[0]), 32'h1);
      chk_val($sformatf("d1_sq%0d", k),   32'(sq[0]),   32'h0);
    end

    // Mid-period reload: D=8, load 2 while cnt=3.
    set_div(0, 8);
    repeat (3) step();
    drive_ld(0, 2);
    step();
    div_ld = '0;
    for (int k = 4; k <= 7; k++) begin
      chk_val($sformatf("mid_pend%0d", k), 32'(pend[0]), 32'h1);
      chk_val($sformatf("mid_tick%0d", k), 32'(tick[0]), 32'h0);
      step();
    end
    chk_val("mid_wrap_tick", 32'(tick[0]), 32'h1);
    chk_val("mid_wrap_pend", 32'(pend[0]), 32'h0);
    chk_val("mid_wrap_sq",   32'(sq[0]),   32'h1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_val($sformatf("mid_d2_tick%0d", k), 32'(tick[0]), 32'((k % 2) == 0));
    end

    // Collision: pending 9, load 5 on the wrap edge.
    set_div(0, 4);
    step();
    drive_ld(0, 9);
    step();
    div_ld = '0;
    chk_val("col_pend9", 32'(pend[0]), 32'h1);
    step();
    drive_ld(0, 5);
    step();
    div_ld = '0;
    chk_val("col_tick", 32'(tick[0]), 32'h1);
    chk_val("col_pend", 32'(pend[0]), 32'h0);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk_val($sformatf("col_d5_tick%0d", k), 32'(tick[0]), 32'((k % 5) == 0));
    end

    // sync_clr alignment: ch0 D=6, ch1 D=3 with different phases.
    set_div(0, 6);
    step();
    step();
    set_div(1, 3);
    repeat (4) step();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    chk_val("sc_tick", 32'(tick[1:0]), 32'h0);
    chk_val("sc_sq",   32'(sq[1:0]),   32'h0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk_val($sformatf("sc_tick0_%0d", k), 32'(tick[0]), 32'((k % 6) == 0));
      chk_val($sformatf("sc_tick1_%0d", k), 32'(tick[1]), 32'((k % 3) == 0));
    end
    en[1] = 1'b0;
    repeat (2) step();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_val($sformatf("sc_off_tick0_%0d", k), 32'(tick[0]), 32'((k % 6) == 0));
      chk_val($sformatf("sc_off_tick1_%0d", k), 32'(tick[1]), 32'h0);
      chk_val($sformatf("sc_off_sq1_%0d", k),   32'(sq[1]),   32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
